// File: rtl/dctq_pkg.sv
// Shared constants for the DCTQ quantiser: default widths and rounding-mode encodings.
package dctq_pkg;

    localparam int DCTQ_DW    = 12;
    localparam int DCTQ_QW    = 8;
    localparam int DCTQ_OW    = 9;
    localparam int DCTQ_SHIFT = 12;
    localparam int DCTQ_BLK   = 64;

    localparam logic RND_TRUNC   = 1'b0;
    localparam logic RND_HALF_UP = 1'b1;

endpackage

// File: rtl/dctq_quant_pipe_if.sv
// Streaming handshake bundle for the quantiser: coefficient in, quantised result out.
interface dctq_quant_pipe_if
    import dctq_pkg::*;
#(
    parameter int DW = DCTQ_DW,
    parameter int OW = DCTQ_OW,
    parameter int AW = $clog2(DCTQ_BLK)
) ();

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          rnd_mode;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          out_last;
    logic          out_sat;

    // Producer/consumer side that feeds coefficients and drains results.
    modport master (
        output in_valid, in_data, rnd_mode, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, out_sat
    );

    // Quantiser side.
    modport slave (
        input  in_valid, in_data, rnd_mode, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, out_sat
    );

endinterface

// File: rtl/dctq_qtable.sv
// Per-position quantisation factor table: BLK x QW registers, one write port,
// one combinational read port (a same-cycle write is seen only after the edge).
module dctq_qtable
    import dctq_pkg::*;
#(
    parameter int QW  = DCTQ_QW,
    parameter int BLK = DCTQ_BLK,
    parameter int AW  = $clog2(BLK)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [QW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [QW-1:0] rdata
);

    logic [QW-1:0] mem_r [BLK];

    // Register file storage: cleared on reset, one entry written per strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BLK; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/dctq_quant_pipe.sv
// Two-stage streaming quantiser: stage 1 multiplies the coefficient by the
// table factor for the current block position, stage 2 rounds, shifts and
// saturates into the registered output. Both stages stall together.
module dctq_quant_pipe
    import dctq_pkg::*;
#(
    parameter int DW    = DCTQ_DW,
    parameter int QW    = DCTQ_QW,
    parameter int OW    = DCTQ_OW,
    parameter int SHIFT = DCTQ_SHIFT,
    parameter int BLK   = DCTQ_BLK,
    parameter int AW    = $clog2(BLK)
) (
    input  logic                clk,
    input  logic                rst,
    dctq_quant_pipe_if.slave    bus,
    input  logic                tbl_we,
    input  logic [AW-1:0]       tbl_addr,
    input  logic [QW-1:0]       tbl_data
);

    // Product width, plus one guard bit so adding the rounding constant cannot overflow.
    localparam int PW = DW + QW + 1;
    localparam int SW = PW + 1;

    localparam logic signed [SW-1:0] HALF    = {{(SW-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    logic                 adv_s;
    logic                 in_fire_s;
    logic [QW-1:0]        qfac_s;
    logic signed [PW-1:0] prod_s;
    logic signed [SW-1:0] sum_s;
    logic signed [SW-1:0] shr_s;
    logic [OW-1:0]        res_s;
    logic                 sat_s;

    logic                 s1_valid_r;
    logic signed [PW-1:0] s1_prod_r;
    logic [AW-1:0]        s1_idx_r;
    logic                 s1_rnd_r;
    logic [AW-1:0]        idx_r;

    // The pipe moves only when the output register is free or being drained.
    assign adv_s        = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = adv_s;
    assign in_fire_s    = bus.in_valid && adv_s;

    dctq_qtable #(
        .QW  (QW),
        .BLK (BLK),
        .AW  (AW)
    ) u_qtable (
        .clk   (clk),
        .rst   (rst),
        .we    (tbl_we),
        .waddr (tbl_addr),
        .wdata (tbl_data),
        .raddr (idx_r),
        .rdata (qfac_s)
    );

    // Factor is unsigned, so it gets a zero sign bit before the signed multiply.
    assign prod_s = PW'($signed(bus.in_data)) * PW'($signed({1'b0, qfac_s}));
    assign sum_s  = SW'(s1_prod_r) + ((s1_rnd_r == RND_HALF_UP) ? HALF : '0);
    assign shr_s  = sum_s >>> SHIFT;

    // Clip the shifted value into the signed output range and flag clipping.
    always_comb begin
        res_s = shr_s[OW-1:0];
        sat_s = 1'b0;
        if (shr_s > SAT_MAX) begin
            res_s = SAT_MAX[OW-1:0];
            sat_s = 1'b1;
        end else if (shr_s < SAT_MIN) begin
            res_s = SAT_MIN[OW-1:0];
            sat_s = 1'b1;
        end else begin
            res_s = shr_s[OW-1:0];
            sat_s = 1'b0;
        end
    end

    // Block position counter; wraps naturally because BLK is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r <= '0;
        end else if (in_fire_s) begin
            idx_r <= idx_r + AW'(1);
        end
    end

    // Stage 1: capture product, position and rounding mode; bubbles clear the valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_prod_r  <= '0;
            s1_idx_r   <= '0;
            s1_rnd_r   <= RND_TRUNC;
        end else if (adv_s) begin
            s1_valid_r <= in_fire_s;
            if (in_fire_s) begin
                s1_prod_r <= prod_s;
                s1_idx_r  <= idx_r;
                s1_rnd_r  <= bus.rnd_mode;
            end
        end
    end

    // Stage 2: registered result; payload only changes when a new valid result lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_idx   <= '0;
            bus.out_last  <= 1'b0;
            bus.out_sat   <= 1'b0;
        end else if (adv_s) begin
            bus.out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                bus.out_data <= res_s;
                bus.out_idx  <= s1_idx_r;
                bus.out_last <= (s1_idx_r == AW'(BLK - 1));
                bus.out_sat  <= sat_s;
            end
        end
    end

endmodule

// File: tb/tb_dctq_quant_pipe.sv
// Self-checking bench for dctq_quant_pipe: a default instance (OW=9) and an
// OW=6 instance share all stimulus; a queue-based reference model predicts
// every result from the arithmetic definition of the quantiser.
module tb_dctq_quant_pipe;
    import dctq_pkg::*;

    localparam int SHIFT = 12;
    localparam int BLK   = 64;

    typedef struct {
        int data;
        int idx;
        int sat;
        int last;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tbl_we = 1'b0;
    logic [5:0] tbl_addr = 6'd0;
    logic [7:0] tbl_data = 8'd0;

    int checks   = 0;
    int failures = 0;

    rec_t q_a[$], q_b[$], log_a[$], log_b[$];
    int   m_tbl[BLK];
    int   m_idx = 0;

    always #5 clk = ~clk;

    dctq_quant_pipe_if #(.DW(12), .OW(9), .AW(6)) bus_a ();
    dctq_quant_pipe_if #(.DW(12), .OW(6), .AW(6)) bus_b ();

    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.in_data   = bus_a.in_data;
    assign bus_b.rnd_mode  = bus_a.rnd_mode;
    assign bus_b.out_ready = bus_a.out_ready;

    dctq_quant_pipe dut_a (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_a),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data)
    );

    dctq_quant_pipe #(.OW(6)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_b),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: exact product, optional +half, floor division, clamp to ow bits.
    function automatic int model_q(input int d, input int q, input bit r, input int ow, output int sat);
        longint p, s, rq, hi, lo;
        p = longint'(d) * longint'(q);
        if (r) p = p + (longint'(1) << (SHIFT - 1));
        s = longint'(1) << SHIFT;
        if (p >= 0) rq = p / s;
        else        rq = -((-p + s - 1) / s);
        hi  = (longint'(1) << (ow - 1)) - 1;
        lo  = -hi - 1;
        sat = 0;
        if (rq > hi) begin
            rq  = hi;
            sat = 1;
        end else if (rq < lo) begin
            rq  = lo;
            sat = 1;
        end
        return int'(rq);
    endfunction

    // Scoreboard: observe handshakes half a cycle before the edge that commits them.
    always @(negedge clk) begin
        rec_t e, o;
        int   s, d;
        if (rst) begin
            q_a.delete();
            q_b.delete();
            m_idx = 0;
            for (int i = 0; i < BLK; i++) m_tbl[i] = 0;
        end else begin
            if (bus_a.out_valid && bus_a.out_ready) begin
                o.data = int'($signed(bus_a.out_data));
                o.idx  = int'(bus_a.out_idx);
                o.sat  = int'(bus_a.out_sat);
                o.last = int'(bus_a.out_last);
                log_a.push_back(o);
                if (q_a.size() == 0) chk("a_extra_output", 1, 0);
                else begin
                    e = q_a.pop_front();
                    chk("a_data", o.data, e.data);
                    chk("a_idx",  o.idx,  e.idx);
                    chk("a_sat",  o.sat,  e.sat);
                    chk("a_last", o.last, e.last);
                end
            end
            if (bus_b.out_valid && bus_b.out_ready) begin
                o.data = int'($signed(bus_b.out_data));
                o.idx  = int'(bus_b.out_idx);
                o.sat  = int'(bus_b.out_sat);
                o.last = int'(bus_b.out_last);
                log_b.push_back(o);
                if (q_b.size() == 0) chk("b_extra_output", 1, 0);
                else begin
                    e = q_b.pop_front();
                    chk("b_data", o.data, e.data);
                    chk("b_idx",  o.idx,  e.idx);
                    chk("b_sat",  o.sat,  e.sat);
                    chk("b_last", o.last, e.last);
                end
            end
            if (bus_a.in_valid && bus_a.in_ready) begin
                d      = int'($signed(bus_a.in_data));
                e.idx  = m_idx;
                e.last = (m_idx == BLK - 1) ? 1 : 0;
                e.data = model_q(d, m_tbl[m_idx], bus_a.rnd_mode, 9, s);
                e.sat  = s;
                q_a.push_back(e);
                e.data = model_q(d, m_tbl[m_idx], bus_a.rnd_mode, 6, s);
                e.sat  = s;
                q_b.push_back(e);
                m_idx  = (m_idx + 1) % BLK;
            end
            if (tbl_we) m_tbl[tbl_addr] = int'(tbl_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] d, input logic r);
        bit done = 1'b0;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = d;
        bus_a.rnd_mode = r;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = bus_a.in_ready;
            tick();
        end
        if (!done) chk("send_timeout", 0, 1);
        bus_a.in_valid = 1'b0;
    endtask

    task automatic tbl_write(input logic [5:0] a, input logic [7:0] v);
        tbl_we   = 1'b1;
        tbl_addr = a;
        tbl_data = v;
        tick();
        tbl_we   = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            tick();
        end
        chk("drain_pending", q_a.size() + q_b.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_a, base_b, nlast, got, sd, si, sl, ss;
        bus_a.in_valid  = 1'b0;
        bus_a.in_data   = 12'd0;
        bus_a.rnd_mode  = 1'b0;
        bus_a.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_in_ready",  int'(bus_a.in_ready), 1);
        chk("rst_out_valid", int'(bus_a.out_valid), 0);
        chk("rst_out_data",  int'($signed(bus_a.out_data)), 0);
        chk("rst_out_idx",   int'(bus_a.out_idx), 0);
        chk("rst_out_last",  int'(bus_a.out_last), 0);
        chk("rst_out_sat",   int'(bus_a.out_sat), 0);
        rst = 1'b0;
        tick();

        // Full-scale factor, negative full-scale input; OW=6 instance clips
        base_a = log_a.size();
        base_b = log_b.size();
        tbl_write(6'd0, 8'd255);
        tbl_write(6'd1, 8'd255);
        tbl_write(6'd2, 8'd255);
        send(12'h800, RND_TRUNC);
        send(12'h800, RND_HALF_UP);
        send(12'h7FF, RND_TRUNC);
        drain();
        chk("t1_count", log_a.size() - base_a, 3);
        chk("t1_trunc_neg",    log_a[base_a].data, -128);
        chk("t1_trunc_sat",    log_a[base_a].sat, 0);
        chk("t1_round_neg",    log_a[base_a + 1].data, -127);
        chk("t1_round_sat",    log_a[base_a + 1].sat, 0);
        chk("t1_pos",          log_a[base_a + 2].data, 127);
        chk("t1_ow6_min",      log_b[base_b].data, -32);
        chk("t1_ow6_min_sat",  log_b[base_b].sat, 1);
        chk("t1_ow6_max",      log_b[base_b + 2].data, 31);
        chk("t1_ow6_max_sat",  log_b[base_b + 2].sat, 1);

        // Small factors around the rounding threshold, both modes
        for (int m = 0; m < 2; m++) begin
            pulse_rst();
            tbl_write(6'd0, 8'd20);
            tbl_write(6'd1, 8'd21);
            tbl_write(6'd2, 8'd41);
            base_a = log_a.size();
            for (int k = 0; k < 3; k++) send(12'd100, (m == 0) ? RND_HALF_UP : RND_TRUNC);
            drain();
            chk("t2_count", log_a.size() - base_a, 3);
            chk("t2_d0", log_a[base_a].data, 0);
            chk("t2_d1", log_a[base_a + 1].data, (m == 0) ? 1 : 0);
            chk("t2_d2", log_a[base_a + 2].data, 1);
            chk("t2_i2", log_a[base_a + 2].idx, 2);
        end

        // 130 back-to-back coefficients over a random table: block wrap
        pulse_rst();
        for (int i = 0; i < BLK; i++) tbl_write(6'(i), 8'($urandom));
        base_a = log_a.size();
        for (int i = 0; i < 130; i++) send(12'($urandom), 1'($urandom));
        drain();
        chk("t4_count", log_a.size() - base_a, 130);
        nlast = 0;
        for (int i = 0; i < 130; i++) nlast += log_a[base_a + i].last;
        chk("t4_last_count", nlast, 2);
        chk("t4_last63",  log_a[base_a + 63].last, 1);
        chk("t4_last127", log_a[base_a + 127].last, 1);
        chk("t4_wrap64",  log_a[base_a + 64].idx, 0);

        // Backpressure: 5-cycle stall, then random ready, with table writes mixed in
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(12'($urandom), 1'($urandom));
                end
            end
            begin
                repeat (6) tick();
                got = 0;
                for (int i = 0; i < 50 && got == 0; i++) begin
                    if (bus_a.out_valid) got = 1;
                    else tick();
                end
                chk("t5_stall_found", got, 1);
                bus_a.out_ready = 1'b0;
                sd = int'($signed(bus_a.out_data));
                si = int'(bus_a.out_idx);
                sl = int'(bus_a.out_last);
                ss = int'(bus_a.out_sat);
                repeat (5) begin
                    tick();
                    chk("t5_in_ready",  int'(bus_a.in_ready), 0);
                    chk("t5_out_valid", int'(bus_a.out_valid), 1);
                    chk("t5_hold_data", int'($signed(bus_a.out_data)), sd);
                    chk("t5_hold_idx",  int'(bus_a.out_idx), si);
                    chk("t5_hold_last", int'(bus_a.out_last), sl);
                    chk("t5_hold_sat",  int'(bus_a.out_sat), ss);
                end
                bus_a.out_ready = 1'b1;
                for (int i = 0; i < 80; i++) begin
                    tick();
                    bus_a.out_ready = 1'($urandom);
                end
                bus_a.out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) tbl_write(6'($urandom), 8'($urandom));
                    else tick();
                end
            end
        join
        bus_a.out_ready = 1'b1;
        drain();

        // Reset with two results in flight
        bus_a.out_ready = 1'b0;
        send(12'($urandom), RND_TRUNC);
        send(12'($urandom), RND_TRUNC);
        chk("t6_pre_valid", int'(bus_a.out_valid), 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", int'(bus_a.out_valid), 0);
        chk("t6_rst_ready", int'(bus_a.in_ready), 1);
        tick();
        rst = 1'b0;
        bus_a.out_ready = 1'b1;
        base_a = log_a.size();
        send(12'h123, RND_HALF_UP);
        drain();
        chk("t6_count", log_a.size() - base_a, 1);
        chk("t6_idx",   log_a[base_a].idx, 0);
        chk("t6_data",  log_a[base_a].data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
